dram_cmd_issuer: RTL and testbench

- Memory-side consumer of the request queue.
- Takes one aged-out request per handshake, decodes the 33-bit address into bank group, bank, row and column, and tracks one open row per bank.
- Issues DDR4 ACT/PRE/RD/WR commands on DIMM clock edges (DIMM clock = CPU_clock/2) and enforces core timing parameters.
- Logs every issued command with `$display` for the command trace file.

---
 rtl/global_defs_pkg.sv | 59 +++++
 rtl/dram_addr_decode.sv | 22 ++
 rtl/dram_cmd_issuer.sv | 222 ++++++++++++++++++++++
 tb/tb_dram_cmd_issuer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/global_defs_pkg.sv
// rtl/global_defs_pkg.sv - shared request/command types, address field map and DDR4 timing defaults
package global_defs;

    typedef enum logic [1:0] {
        DATA_READ         = 2'd0,
        DATA_WRITE        = 2'd1,
        INSTRUCTION_FETCH = 2'd2
    } opcode_e;

    typedef struct packed {
        opcode_e     opcode;
        logic [32:0] address;
        logic [63:0] CPU_clock_count;
        logic [31:0] life;
    } parser_out_struct;

    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_ACT = 3'd1,
        CMD_PRE = 3'd2,
        CMD_RD  = 3'd3,
        CMD_WR  = 3'd4
    } dram_cmd_e;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHECK     = 3'd1,
        ISSUE_PRE = 3'd2,
        ISSUE_ACT = 3'd3,
        ISSUE_RW  = 3'd4,
        WAIT_DATA = 3'd5
    } issuer_state_e;

    localparam int ROW_MSB   = 32;
    localparam int ROW_LSB   = 18;
    localparam int COLH_MSB  = 17;
    localparam int COLH_LSB  = 10;
    localparam int BA_MSB    = 9;
    localparam int BA_LSB    = 8;
    localparam int BG_MSB    = 7;
    localparam int BG_LSB    = 6;
    localparam int COLL_MSB  = 5;
    localparam int COLL_LSB  = 3;
    localparam int BYTE_MSB  = 2;
    localparam int BYTE_LSB  = 0;

    localparam int unsigned DEF_TRCD   = 24;
    localparam int unsigned DEF_TRP    = 24;
    localparam int unsigned DEF_TRAS   = 52;
    localparam int unsigned DEF_TCL    = 24;
    localparam int unsigned DEF_TCWL   = 20;
    localparam int unsigned DEF_TBURST = 4;

    // Counters are loaded in the issue cycle, which already counts as the first waited CPU cycle.
    function automatic logic [15:0] wait_load(input int unsigned dimm_cycles);
        return (dimm_cycles == 0) ? 16'd0 : 16'(2 * dimm_cycles - 1);
    endfunction

endpackage

// File: rtl/dram_addr_decode.sv
// rtl/dram_addr_decode.sv - combinational split of a 33-bit request address into DDR4 fields
module dram_addr_decode
    import global_defs::*;
(
    input  logic [32:0] addr,
    output logic [1:0]  bg,
    output logic [1:0]  ba,
    output logic [14:0] row,
    output logic [7:0]  col_hi,
    output logic [2:0]  col_lo
);

    logic [2:0] unused_byte;

    assign row         = addr[ROW_MSB:ROW_LSB];
    assign col_hi      = addr[COLH_MSB:COLH_LSB];
    assign ba          = addr[BA_MSB:BA_LSB];
    assign bg          = addr[BG_MSB:BG_LSB];
    assign col_lo      = addr[COLL_MSB:COLL_LSB];
    assign unused_byte = addr[BYTE_MSB:BYTE_LSB];

endmodule

// File: rtl/dram_cmd_issuer.sv
// rtl/dram_cmd_issuer.sv - issues DDR4 ACT/PRE/RD/WR per request with open-page row tracking
module dram_cmd_issuer
    import global_defs::*;
#(
    parameter int unsigned TRCD   = DEF_TRCD,
    parameter int unsigned TRP    = DEF_TRP,
    parameter int unsigned TRAS   = DEF_TRAS,
    parameter int unsigned TCL    = DEF_TCL,
    parameter int unsigned TCWL   = DEF_TCWL,
    parameter int unsigned TBURST = DEF_TBURST
) (
    input  logic             CPU_clock,
    input  logic             rst_n,
    input  logic             req_valid,
    input  parser_out_struct req,
    output logic             req_ready,
    output logic             drop_err,
    output logic             cmd_valid,
    output dram_cmd_e        cmd,
    output logic [1:0]       cmd_bg,
    output logic [1:0]       cmd_ba,
    output logic [14:0]      cmd_addr,
    output logic             done
);

    localparam logic [15:0] LD_TRCD = wait_load(TRCD);
    localparam logic [15:0] LD_TRP  = wait_load(TRP);
    localparam logic [15:0] LD_RD   = wait_load(TCL + TBURST);
    localparam logic [15:0] LD_WR   = wait_load(TCWL + TBURST);
    localparam logic [15:0] RAS_MIN = 16'(2 * TRAS);

    logic [1:0]  dec_bg, dec_ba;
    logic [14:0] dec_row;
    logic [7:0]  dec_col_hi;
    logic [2:0]  dec_col_lo;
    logic        unused_req_bits;

    dram_addr_decode u_addr_decode (
        .addr   (req.address),
        .bg     (dec_bg),
        .ba     (dec_ba),
        .row    (dec_row),
        .col_hi (dec_col_hi),
        .col_lo (dec_col_lo)
    );

    assign unused_req_bits = ^{req.CPU_clock_count, req.life, dec_col_lo[0]};

    issuer_state_e state_q, state_d;
    logic [1:0]    bg_q, bg_d, ba_q, ba_d;
    logic [14:0]   row_q, row_d;
    logic [9:0]    col_q, col_d;
    logic          is_wr_q, is_wr_d;
    logic [15:0]   open_q, open_d;
    logic [14:0]   open_row_q [16];
    logic [14:0]   open_row_d [16];
    logic [15:0]   ras_cnt_q, ras_cnt_d;
    logic [3:0]    ras_bank_q, ras_bank_d;
    logic [15:0]   wait_cnt_q, wait_cnt_d;
    logic          dimm_phase_q, dimm_phase_d;
    logic          req_ready_q, req_ready_d;
    logic          drop_err_q, drop_err_d;
    logic          cmd_valid_q, cmd_valid_d;
    dram_cmd_e     cmd_q, cmd_d;
    logic [1:0]    cmd_bg_q, cmd_bg_d, cmd_ba_q, cmd_ba_d;
    logic [14:0]   cmd_addr_q, cmd_addr_d;
    logic          done_q, done_d;

    logic [3:0] bank_idx;
    logic       dimm_edge, wait_zero, tras_ok;

    assign bank_idx  = {bg_q, ba_q};
    assign dimm_edge = !dimm_phase_q;
    assign wait_zero = (wait_cnt_q == 16'd0);
    assign tras_ok   = (ras_bank_q != bank_idx) || (ras_cnt_q >= RAS_MIN);

    always_comb begin
        state_d      = state_q;
        bg_d         = bg_q;
        ba_d         = ba_q;
        row_d        = row_q;
        col_d        = col_q;
        is_wr_d      = is_wr_q;
        open_d       = open_q;
        open_row_d   = open_row_q;
        ras_cnt_d    = (ras_cnt_q == 16'hFFFF) ? ras_cnt_q : ras_cnt_q + 16'd1;
        ras_bank_d   = ras_bank_q;
        wait_cnt_d   = wait_zero ? 16'd0 : wait_cnt_q - 16'd1;
        dimm_phase_d = !dimm_phase_q;
        drop_err_d   = req_valid && !req_ready_q;
        cmd_valid_d  = 1'b0;
        cmd_d        = CMD_NOP;
        cmd_bg_d     = 2'd0;
        cmd_ba_d     = 2'd0;
        cmd_addr_d   = 15'd0;
        done_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    bg_d    = dec_bg;
                    ba_d    = dec_ba;
                    row_d   = dec_row;
                    col_d   = {dec_col_hi, dec_col_lo[2:1]};
                    is_wr_d = (req.opcode == DATA_WRITE);
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (!open_q[bank_idx])                  state_d = ISSUE_ACT;
                else if (open_row_q[bank_idx] == row_q) state_d = ISSUE_RW;
                else                                    state_d = ISSUE_PRE;
            end
            ISSUE_PRE: begin
                if (dimm_edge && wait_zero && tras_ok) begin
                    cmd_valid_d      = 1'b1;
                    cmd_d            = CMD_PRE;
                    cmd_bg_d         = bg_q;
                    cmd_ba_d         = ba_q;
                    wait_cnt_d       = LD_TRP;
                    open_d[bank_idx] = 1'b0;
                    state_d          = ISSUE_ACT;
                end
            end
            ISSUE_ACT: begin
                if (dimm_edge && wait_zero) begin
                    cmd_valid_d          = 1'b1;
                    cmd_d                = CMD_ACT;
                    cmd_bg_d             = bg_q;
                    cmd_ba_d             = ba_q;
                    cmd_addr_d           = row_q;
                    wait_cnt_d           = LD_TRCD;
                    open_d[bank_idx]     = 1'b1;
                    open_row_d[bank_idx] = row_q;
                    // ras_cnt holds CPU cycles elapsed since the ACT cycle itself
                    ras_cnt_d            = 16'd1;
                    ras_bank_d           = bank_idx;
                    state_d              = ISSUE_RW;
                end
            end
            ISSUE_RW: begin
                if (dimm_edge && wait_zero) begin
                    cmd_valid_d = 1'b1;
                    cmd_d       = is_wr_q ? CMD_WR : CMD_RD;
                    cmd_bg_d    = bg_q;
                    cmd_ba_d    = ba_q;
                    cmd_addr_d  = {5'd0, col_q};
                    wait_cnt_d  = is_wr_q ? LD_WR : LD_RD;
                    state_d     = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (wait_zero) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge CPU_clock) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            bg_q         <= 2'd0;
            ba_q         <= 2'd0;
            row_q        <= 15'd0;
            col_q        <= 10'd0;
            is_wr_q      <= 1'b0;
            open_q       <= 16'd0;
            ras_cnt_q    <= 16'd0;
            ras_bank_q   <= 4'd0;
            wait_cnt_q   <= 16'd0;
            dimm_phase_q <= 1'b0;
            req_ready_q  <= 1'b1;
            drop_err_q   <= 1'b0;
            cmd_valid_q  <= 1'b0;
            cmd_q        <= CMD_NOP;
            cmd_bg_q     <= 2'd0;
            cmd_ba_q     <= 2'd0;
            cmd_addr_q   <= 15'd0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bg_q         <= bg_d;
            ba_q         <= ba_d;
            row_q        <= row_d;
            col_q        <= col_d;
            is_wr_q      <= is_wr_d;
            open_q       <= open_d;
            ras_cnt_q    <= ras_cnt_d;
            ras_bank_q   <= ras_bank_d;
            wait_cnt_q   <= wait_cnt_d;
            dimm_phase_q <= dimm_phase_d;
            req_ready_q  <= req_ready_d;
            drop_err_q   <= drop_err_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_q        <= cmd_d;
            cmd_bg_q     <= cmd_bg_d;
            cmd_ba_q     <= cmd_ba_d;
            cmd_addr_q   <= cmd_addr_d;
            done_q       <= done_d;
        end
    end

    // Row values are only meaningful behind a set open bit, so they need no reset.
    always_ff @(posedge CPU_clock) begin
        open_row_q <= open_row_d;
    end

    assign req_ready = req_ready_q;
    assign drop_err  = drop_err_q;
    assign cmd_valid = cmd_valid_q;
    assign cmd       = cmd_q;
    assign cmd_bg    = cmd_bg_q;
    assign cmd_ba    = cmd_ba_q;
    assign cmd_addr  = cmd_addr_q;
    assign done      = done_q;

endmodule

// File: tb/tb_dram_cmd_issuer.sv
// tb/tb_dram_cmd_issuer.sv - scoreboard bench for dram_cmd_issuer, default and fast timing instances
module tb_dram_cmd_issuer;
    import global_defs::*;

    typedef struct {
        dram_cmd_e   cmd;
        logic [1:0]  bg;
        logic [1:0]  ba;
        logic [14:0] addr;
        int          cyc;
    } exp_cmd_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc;
    int   n_checks = 0;
    int   n_pass = 0;

    logic             req_valid_a, req_valid_b;
    parser_out_struct req_a, req_b;
    logic             req_ready_a, drop_err_a, cmd_valid_a, done_a;
    logic             req_ready_b, drop_err_b, cmd_valid_b, done_b;
    dram_cmd_e        cmd_a, cmd_b;
    logic [1:0]       cmd_bg_a, cmd_ba_a, cmd_bg_b, cmd_ba_b;
    logic [14:0]      cmd_addr_a, cmd_addr_b;

    exp_cmd_t exp_a[$];
    exp_cmd_t exp_b[$];
    int       exp_done_a[$];
    int       exp_done_b[$];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    dram_cmd_issuer dut_a (
        .CPU_clock (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid_a),
        .req       (req_a),
        .req_ready (req_ready_a),
        .drop_err  (drop_err_a),
        .cmd_valid (cmd_valid_a),
        .cmd       (cmd_a),
        .cmd_bg    (cmd_bg_a),
        .cmd_ba    (cmd_ba_a),
        .cmd_addr  (cmd_addr_a),
        .done      (done_a)
    );

    dram_cmd_issuer #(.TRCD(2), .TCL(2), .TBURST(1), .TRAS(20)) dut_b (
        .CPU_clock (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid_b),
        .req       (req_b),
        .req_ready (req_ready_b),
        .drop_err  (drop_err_b),
        .cmd_valid (cmd_valid_b),
        .cmd       (cmd_b),
        .cmd_bg    (cmd_bg_b),
        .cmd_ba    (cmd_ba_b),
        .cmd_addr  (cmd_addr_b),
        .done      (done_b)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_cmd(input int which, input dram_cmd_e c, input logic [1:0] bg,
                            input logic [1:0] ba, input logic [14:0] a, input int issue_cyc);
        exp_cmd_t e;
        e.cmd = c; e.bg = bg; e.ba = ba; e.addr = a;
        e.cyc = issue_cyc + 1;
        if (which == 0) exp_a.push_back(e);
        else            exp_b.push_back(e);
    endtask

    task automatic push_done(input int which, input int done_cyc);
        if (which == 0) exp_done_a.push_back(done_cyc + 1);
        else            exp_done_b.push_back(done_cyc + 1);
    endtask

    task automatic set_req(input int which, input opcode_e op, input logic [32:0] addr);
        parser_out_struct r;
        r.opcode          = op;
        r.address         = addr;
        r.CPU_clock_count = 64'(cyc);
        r.life            = $urandom;
        if (which == 0) begin req_a = r; req_valid_a = 1'b1; end
        else            begin req_b = r; req_valid_b = 1'b1; end
    endtask

    task automatic clr_req();
        req_valid_a = 1'b0;
        req_valid_b = 1'b0;
    endtask

    task automatic observe(input int which, input logic cv, input dram_cmd_e c, input logic [1:0] bg,
                           input logic [1:0] ba, input logic [14:0] a, input logic dn);
        exp_cmd_t e;
        string    p;
        int       n_left;
        int       d;
        p = (which == 0) ? "a" : "b";
        if (cv) begin
            $display("%0t dimm=%0d %s %s bg=%0d ba=%0d addr=%04h", $time, cyc / 2, p, c.name(), bg, ba, a);
            n_left = (which == 0) ? exp_a.size() : exp_b.size();
            if (n_left == 0) check_eq({p, "_extra_cmd"}, 64'(cv), 64'd0);
            else begin
                if (which == 0) e = exp_a.pop_front();
                else            e = exp_b.pop_front();
                check_eq({p, "_cmd_cycle"}, 64'(cyc), 64'(e.cyc));
                check_eq({p, "_cmd"}, 64'(c), 64'(e.cmd));
                check_eq({p, "_cmd_bg_ba"}, 64'({bg, ba}), 64'({e.bg, e.ba}));
                check_eq({p, "_cmd_addr"}, 64'(a), 64'(e.addr));
            end
        end
        if (dn) begin
            n_left = (which == 0) ? exp_done_a.size() : exp_done_b.size();
            if (n_left == 0) check_eq({p, "_extra_done"}, 64'(dn), 64'd0);
            else begin
                if (which == 0) d = exp_done_a.pop_front();
                else            d = exp_done_b.pop_front();
                check_eq({p, "_done_cycle"}, 64'(cyc), 64'(d));
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            observe(0, cmd_valid_a, cmd_a, cmd_bg_a, cmd_ba_a, cmd_addr_a, done_a);
            observe(1, cmd_valid_b, cmd_b, cmd_bg_b, cmd_ba_b, cmd_addr_b, done_b);
        end
    end

    task automatic check_reset_a(input string p);
        check_eq({p, "_req_ready"}, 64'(req_ready_a), 64'd1);
        check_eq({p, "_drop_err"}, 64'(drop_err_a), 64'd0);
        check_eq({p, "_cmd_valid"}, 64'(cmd_valid_a), 64'd0);
        check_eq({p, "_cmd"}, 64'(cmd_a), 64'(CMD_NOP));
        check_eq({p, "_cmd_fields"}, 64'({cmd_bg_a, cmd_ba_a, cmd_addr_a}), 64'd0);
        check_eq({p, "_done"}, 64'(done_a), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        clr_req();
        req_a = '0;
        req_b = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // cycle 0: reset values, then first requests to both instances
        check_reset_a("rst0_a");
        check_eq("rst0_b_req_ready", 64'(req_ready_b), 64'd1);
        check_eq("rst0_b_cmd_valid", 64'(cmd_valid_b), 64'd0);
        check_eq("rst0_b_drop_err", 64'(drop_err_b), 64'd0);

        set_req(0, DATA_READ, 33'h0_0004_0000);
        push_cmd(0, CMD_ACT, 2'd0, 2'd0, 15'h0001, 2);
        push_cmd(0, CMD_RD,  2'd0, 2'd0, 15'h0000, 50);
        push_done(0, 106);

        set_req(1, DATA_READ, 33'h0_0154_0380);
        push_cmd(1, CMD_ACT, 2'd2, 2'd3, 15'h0055, 2);
        push_cmd(1, CMD_RD,  2'd2, 2'd3, 15'h0000, 6);
        push_done(1, 12);
        goto(1);
        clr_req();

        goto(10);
        check_eq("a_drop_err_before", 64'(drop_err_a), 64'd0);
        set_req(0, DATA_WRITE, 33'h1_2345_6788);
        goto(11);
        clr_req();
        check_eq("a_drop_err_pulse", 64'(drop_err_a), 64'd1);
        check_eq("a_req_ready_busy", 64'(req_ready_a), 64'd0);
        goto(12);
        check_eq("a_drop_err_after", 64'(drop_err_a), 64'd0);

        goto(13);
        check_eq("b_req_ready_idle", 64'(req_ready_b), 64'd1);
        set_req(1, DATA_WRITE, 33'h0_0158_0380);
        push_cmd(1, CMD_PRE, 2'd2, 2'd3, 15'h0000, 42);
        push_cmd(1, CMD_ACT, 2'd2, 2'd3, 15'h0056, 90);
        push_cmd(1, CMD_WR,  2'd2, 2'd3, 15'h0000, 94);
        push_done(1, 136);
        goto(14);
        clr_req();

        goto(106);
        check_eq("a_req_ready_106", 64'(req_ready_a), 64'd0);
        goto(107);
        check_eq("a_req_ready_107", 64'(req_ready_a), 64'd1);

        goto(200);
        set_req(0, DATA_WRITE, 33'h0_0006_9435);
        push_cmd(0, CMD_WR, 2'd0, 2'd0, 15'h0297, 202);
        push_done(0, 250);
        goto(201);
        clr_req();

        goto(300);
        set_req(0, INSTRUCTION_FETCH, 33'h1_EAF0_0400);
        push_cmd(0, CMD_PRE, 2'd0, 2'd0, 15'h0000, 302);
        push_cmd(0, CMD_ACT, 2'd0, 2'd0, 15'h7ABC, 350);
        push_cmd(0, CMD_RD,  2'd0, 2'd0, 15'h0004, 398);
        push_done(0, 454);
        goto(301);
        clr_req();

        goto(470);
        check_eq("a_cmds_left", 64'(exp_a.size()), 64'd0);
        check_eq("a_dones_left", 64'(exp_done_a.size()), 64'd0);
        check_eq("b_cmds_left", 64'(exp_b.size()), 64'd0);
        check_eq("b_dones_left", 64'(exp_done_b.size()), 64'd0);

        // mid-operation reset during the TRCD wait
        rst_n = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        set_req(0, DATA_READ, 33'h0_0004_0000);
        push_cmd(0, CMD_ACT, 2'd0, 2'd0, 15'h0001, 2);
        goto(1);
        clr_req();
        goto(30);
        check_eq("a_act_before_reset", 64'(exp_a.size()), 64'd0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_reset_a("rst31_a");
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;

        set_req(0, DATA_READ, 33'h0_0004_0000);
        push_cmd(0, CMD_ACT, 2'd0, 2'd0, 15'h0001, 2);
        push_cmd(0, CMD_RD,  2'd0, 2'd0, 15'h0000, 50);
        push_done(0, 106);
        goto(1);
        clr_req();
        goto(120);
        check_eq("a_cmds_left_end", 64'(exp_a.size()), 64'd0);
        check_eq("a_dones_left_end", 64'(exp_done_a.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
